// File: rtl/spi_xip_sequencer.sv
// APB front end for the Wishbone SPI master: flash-window reads are expanded into a full
// SPI read sequence, register-window accesses pass straight through one at a time.
module spi_xip_sequencer #(
   parameter logic [31:0] flash_addr_start = 32'h3000_0000,
   parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
   parameter logic [31:0] spi_master_base  = 32'h1000_1000,
   parameter logic [31:0] spi_master_end   = 32'h1000_1fff,
   parameter logic [31:0] xip_divider      = 32'h0000_0001,
   parameter logic [7:0]  xip_ss_mask      = 8'h01,
   parameter int          poll_limit       = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic [4:0]  wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);
   localparam int CW = $clog2(poll_limit + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_DIV, S_TX1, S_TX0, S_SS, S_GO, S_POLL, S_RD, S_SSCLR, S_PT, S_RESP
   } state_t;

   state_t        r_state, w_next, w_hold, w_succ, w_fail_to;
   logic          r_armed, r_cfg_valid, r_err, r_write;
   logic [23:0]   r_addr;
   logic [31:0]   r_wdata, r_rdata;
   logic [3:0]    r_strb;
   logic [CW-1:0] r_poll_cnt;
   logic          r_stb, r_we;
   logic [4:0]    r_adr;
   logic [31:0]   r_dat;
   logic [3:0]    r_sel;
   logic          r_pready, r_pslverr;
   logic [31:0]   r_prdata;

   logic          w_access, w_we, w_ack, w_fail, w_accept, w_in_flash, w_in_reg, w_xip;
   logic          w_poll_busy, w_poll_last, w_err_next, w_cfg_next;
   logic [4:0]    w_adr;
   logic [31:0]   w_dat, w_rdata_next;
   logic [3:0]    w_sel;

   assign w_in_flash  = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
   assign w_in_reg    = (in_paddr >= spi_master_base) && (in_paddr <= spi_master_end);
   assign w_accept    = (r_state == S_IDLE) && in_psel && in_penable && r_armed;
   // A simultaneous ack and err counts as an error only.
   assign w_ack       = r_stb & wb_ack_i & ~wb_err_i;
   assign w_fail      = r_stb & wb_err_i;
   assign w_xip       = r_state inside {S_DIV, S_TX1, S_TX0, S_SS, S_GO, S_POLL, S_RD};
   assign w_poll_busy = wb_dat_i[8];
   assign w_poll_last = (r_poll_cnt == CW'(poll_limit - 1));

   // Next state, the access each state issues, and next values of the status registers
   always_comb begin
      w_hold    = r_state;
      w_succ    = r_state;
      w_fail_to = S_SSCLR;
      w_access  = 1'b1;
      w_adr     = 5'h00;
      w_dat     = 32'h0000_0000;
      w_sel     = 4'hF;
      w_we      = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_access = 1'b0;
            if (!w_accept)                      w_hold = S_IDLE;
            else if (w_in_flash && !in_pwrite)  w_hold = r_cfg_valid ? S_TX1 : S_DIV;
            else if (w_in_reg)                  w_hold = S_PT;
            else                                w_hold = S_RESP;
         end
         S_DIV:   begin w_adr = 5'h14; w_dat = xip_divider;            w_succ = S_TX1;  end
         S_TX1:   begin w_adr = 5'h04; w_dat = {8'h03, r_addr};        w_succ = S_TX0;  end
         S_TX0:   begin w_adr = 5'h00; w_dat = 32'h0000_0000;          w_succ = S_SS;   end
         S_SS:    begin w_adr = 5'h18; w_dat = {24'h00_0000, xip_ss_mask}; w_succ = S_GO; end
         S_GO:    begin w_adr = 5'h10; w_dat = 32'h0000_0540;          w_succ = S_POLL; end
         S_POLL: begin
            w_adr  = 5'h10;
            w_we   = 1'b0;
            w_succ = w_poll_busy ? (w_poll_last ? S_SSCLR : S_POLL) : S_RD;
         end
         S_RD:    begin w_adr = 5'h00; w_we = 1'b0;                    w_succ = S_SSCLR; end
         S_SSCLR: begin w_adr = 5'h18; w_succ = S_RESP; w_fail_to = S_RESP; end
         S_PT: begin
            w_adr     = r_addr[4:0];
            w_dat     = r_wdata;
            w_sel     = r_write ? r_strb : 4'hF;
            w_we      = r_write;
            w_succ    = S_RESP;
            w_fail_to = S_RESP;
         end
         S_RESP:  begin w_access = 1'b0; w_hold = S_IDLE; end
         default: begin w_access = 1'b0; w_hold = S_IDLE; end
      endcase

      if (w_fail)     w_next = w_fail_to;
      else if (w_ack) w_next = w_succ;
      else            w_next = w_hold;

      if (w_accept)                                            w_err_next = !(w_in_flash && !in_pwrite) && !w_in_reg;
      else if (w_fail && r_state != S_SSCLR)                   w_err_next = 1'b1;
      else if (w_ack && r_state == S_POLL && w_poll_busy && w_poll_last) w_err_next = 1'b1;
      else                                                     w_err_next = r_err;

      if (w_accept)                           w_cfg_next = r_cfg_valid & ~(w_in_reg & in_pwrite);
      else if (w_fail && w_xip)               w_cfg_next = 1'b0;
      else if (w_ack && r_state == S_DIV)     w_cfg_next = 1'b1;
      else                                    w_cfg_next = r_cfg_valid;

      // RX0 holds bytes in wire order; APB wants the first byte in the low lane.
      if (w_accept)                           w_rdata_next = 32'h0000_0000;
      else if (w_ack && r_state == S_RD)      w_rdata_next = {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]};
      else if (w_ack && r_state == S_PT)      w_rdata_next = wb_dat_i;
      else                                    w_rdata_next = r_rdata;
   end

   // State, request latches, Wishbone master registers and the registered APB response
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_armed     <= 1'b1;
         r_cfg_valid <= 1'b0;
         r_err       <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= 24'h00_0000;
         r_wdata     <= 32'h0000_0000;
         r_rdata     <= 32'h0000_0000;
         r_strb      <= 4'h0;
         r_poll_cnt  <= '0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_adr       <= 5'h00;
         r_dat       <= 32'h0000_0000;
         r_sel       <= 4'h0;
         r_pready    <= 1'b0;
         r_pslverr   <= 1'b0;
         r_prdata    <= 32'h0000_0000;
      end else begin
         r_state     <= w_next;
         r_err       <= w_err_next;
         r_cfg_valid <= w_cfg_next;
         r_rdata     <= w_rdata_next;
         if (w_accept) begin
            r_addr  <= in_paddr[23:0];
            r_wdata <= in_pwdata;
            r_strb  <= in_pstrb;
            r_write <= in_pwrite;
         end
         // Re-arm only once the master has left the access phase that was just answered.
         if (r_state == S_RESP)  r_armed <= 1'b0;
         else if (!in_penable)   r_armed <= 1'b1;
         if (r_state == S_GO)                                 r_poll_cnt <= '0;
         else if (r_state == S_POLL && w_ack && w_poll_busy)  r_poll_cnt <= r_poll_cnt + CW'(1);
         if (w_access && !r_stb) begin
            r_stb <= 1'b1;
            r_adr <= w_adr;
            r_dat <= w_dat;
            r_sel <= w_sel;
            r_we  <= w_we;
         end else if (w_ack || w_fail) begin
            r_stb <= 1'b0;
         end
         r_pready  <= (w_next == S_RESP) && (r_state != S_RESP);
         r_pslverr <= (w_next == S_RESP) && (r_state != S_RESP) && w_err_next;
         r_prdata  <= ((w_next == S_RESP) && (r_state != S_RESP) && !w_err_next && !r_write)
                      ? w_rdata_next : 32'h0000_0000;
      end
   end

   assign in_pready  = r_pready;
   assign in_prdata  = r_prdata;
   assign in_pslverr = r_pslverr;
   assign wb_adr_o   = r_adr;
   assign wb_dat_o   = r_dat;
   assign wb_sel_o   = r_sel;
   assign wb_we_o    = r_we;
   assign wb_stb_o   = r_stb;
   assign wb_cyc_o   = r_stb;
endmodule

// File: doc/spi_xip_sequencer.md
# spi_xip_sequencer

Sequences the Wishbone SPI master for execute-in-place reads of the SPI NOR flash, and shares that master's register port with direct APB software accesses. Sits between the APB interconnect and `spi_top`. Flash-window reads become the full SPI master programming sequence; register-window accesses pass through, one at a time. It also caches the divider configuration and applies a timeout to the completion poll.

## Interface
- `flash_addr_start`, 32'h30000000: first address of the XIP window.
- `flash_addr_end`, 32'h3fffffff: last address of the XIP window.
- `spi_master_base`, 32'h10001000: first address of the register pass-through window.
- `spi_master_end`, 32'h10001fff: last address of the register pass-through window.
- `xip_divider`, 32'h1: value written to DIVIDER.
- `xip_ss_mask`, 8'h01: SS value selecting the flash.
- `poll_limit`, 1024: maximum CTRL polls before timeout (counter width `$clog2(poll_limit+1)`).

Ports:
- `clock`  in  1  single clock; all logic rises on this edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_paddr`  in  32  APB address.
- `in_psel`  in  1  APB select.
- `in_penable`  in  1  APB enable.
- `in_pwrite`  in  1  APB write.
- `in_pwdata`  in  32  APB write data.
- `in_pstrb`  in  4  APB byte strobes.
- `in_pready`  out  1  APB ready.
- `in_prdata`  out  32  APB read data.
- `in_pslverr`  out  1  APB error.
- `wb_adr_o`  out  5  SPI master register address.
- `wb_dat_o`  out  32  Wishbone write data.
- `wb_dat_i`  in  32  Wishbone read data.
- `wb_sel_o`  out  4  Wishbone byte select.
- `wb_we_o`  out  1  Wishbone write enable.
- `wb_stb_o`  out  1  Wishbone strobe.
- `wb_cyc_o`  out  1  Wishbone cycle.
- `wb_ack_i`  in  1  Wishbone acknowledge.
- `wb_err_i`  in  1  Wishbone error.

## Operation
- SPI master register map: RX0/TX0 0x00, TX1 0x04, CTRL 0x10, DIVIDER 0x14, SS 0x18.
- Request start: IDLE accepts a request when `in_psel & in_penable`. Address and data are latched at acceptance.
- Address decode, inclusive bounds:
  - Flash read → XIP sequence.
  - Register-window read or write → PT.
  - Flash-window write or any other address → RESP with error, no Wishbone activity.
- PT: one Wishbone cycle using `in_paddr[4:0]`, `in_pwdata`, `in_pstrb`, `in_pwrite`. A PT write clears `cfg_valid`. Read data is latched on ack.
- XIP states, each one Wishbone write unless noted:
  - DIV: writes `xip_divider`. Skipped when `cfg_valid=1`; `cfg_valid` is set on DIV ack.
  - TX1: writes {8'h03, addr[23:0]}.
  - TX0: writes 32'h0.
  - SS: writes {24'h0, `xip_ss_mask`}.
  - GO: writes CTRL = 32'h540 (GO bit 8, TX_NEG bit 10, CHAR_LEN 64).
  - POLL: reads CTRL, repeating until bit 8 is 0.
  - RD: reads RX0.
  - SSCLR: writes SS = 0.
  - RESP: returns the response.
- Read data: RX0 = {b0,b1,b2,b3} in wire order. `in_prdata` = {b3,b2,b1,b0}, little-endian.
- Poll timeout: POLL increments a counter per ack with GO still set. On reaching `poll_limit`, the block sets the error flag and goes to SSCLR.
- Wishbone error: `wb_err_i` in any XIP state sets the error flag, goes to SSCLR and clears `cfg_valid`. In PT it goes to RESP with error.
- SSCLR error: a `wb_err_i` during SSCLR still proceeds to RESP.

## Timing
- Reset: state IDLE, `cfg_valid=0`, poll counter 0, error flag 0. All outputs are 0.
- Reset is honoured in any state, including mid-POLL. The SPI master is reset on the same `reset`, so no cleanup access is issued.
- Wishbone cycles:
  - `stb_o`/`cyc_o` are registered, asserted the cycle after state entry, and held with stable address, data and select until `ack_i` or `err_i`.
  - They are deasserted for at least one cycle between accesses.
  - Read `sel_o` = 4'hF.
- APB response:
  - `in_pready` pulses for exactly one cycle in RESP, together with `in_prdata` and `in_pslverr`.
  - `in_prdata` is 0 on writes and on errors.
  - The block returns to IDLE the next cycle and ignores the bus until `in_penable` has been deasserted, so an access phase is not double-accepted.
- XIP latency with single-cycle ack: 8 accesses (7 with `cfg_valid`) plus the POLL count, plus 2 cycles each.
- Simultaneous events: `wb_ack_i` and `wb_err_i` in the same cycle are treated as an error.

## Test plan
- XIP read of 0x30000004, flash bytes 0x11,0x22,0x33,0x44:
  - Wishbone writes in order: 0x14←1, 0x04←0x03000004, 0x00←0, 0x18←1, 0x10←0x540.
  - Then polls, reads 0x00, writes 0x18←0.
  - `in_prdata`=0x44332211, `pslverr`=0.
- Back-to-back XIP reads:
  - The second read issues no DIVIDER write.
  - After a PT write of 0x10001014←4, the next XIP read rewrites DIVIDER←1.
- APB write to 0x30000000 and read of 0x20000000: both give a one-cycle `pready` with `pslverr`=1 and no `wb_cyc_o`.
- PT read of 0x10001010 returning 0x1234: one Wishbone read at address 0x10, `in_prdata`=0x1234.
- CTRL stuck with GO=1: after `poll_limit` polls, SS←0 is written, then `pslverr`=1.
- Reset asserted during POLL: all outputs are 0 immediately; the next XIP read completes with correct data.
